// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for one arbiter-PUF: handshake, setup, fire, sample, relax, majority vote.
// Optional soft-response output rsp_ones is enabled by defining APUF_SOFT_RESP_EN.
module apuf_eval_ctrl #(
  parameter int NSTAGE      = 64,
  parameter int NEVAL       = 5,
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int RELAX_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_valid,
  output logic              ch_ready,
  input  logic [NSTAGE-1:0] ch_data,
  output logic [NSTAGE-1:0] puf_c,
  output logic              puf_tig,
  input  logic              puf_resp_ready,
  input  logic              puf_resp_bit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic              rsp_err,
  output logic              busy
`ifdef APUF_SOFT_RESP_EN
  ,
  output logic [$clog2(NEVAL+1)-1:0] rsp_ones
`endif
);

  localparam int CW = $clog2(NEVAL + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int RW = $clog2(RELAX_CYC + 1);

  localparam logic [CW-1:0] NEVAL_L    = CW'(NEVAL);
  localparam logic [CW-1:0] HALF_L     = CW'(NEVAL / 2);
  localparam logic [WW-1:0] TIMEOUT_L  = WW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
  localparam logic [RW-1:0] RELAX_LAST = RW'(RELAX_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FIRE, S_WAIT, S_SAMPLE, S_RELAX, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NSTAGE-1:0] puf_c_q, puf_c_d;
  logic [CW-1:0]     ones_q, ones_d, eval_q, eval_d;
  logic [WW-1:0]     wait_q, wait_d, wait_nxt;
  logic [SW-1:0]     setup_q, setup_d;
  logic [RW-1:0]     relax_q, relax_d;
  logic              err_q, err_d;
  logic              rsp_bit_q, rsp_bit_d, rsp_err_q, rsp_err_d;
  logic              ch_ready_q, busy_q, puf_tig_q, rsp_valid_q;
  logic              rdy_s1_q, rdy_s_q, bit_s1_q, bit_s_q;

  // NOTE: the PUF outputs settle on their own timing; two flops each keep metastability
  // out of the FSM, and both lines share the same depth so bit_s is valid whenever rdy_s is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_s1_q <= 1'b0;
      rdy_s_q  <= 1'b0;
      bit_s1_q <= 1'b0;
      bit_s_q  <= 1'b0;
    end else begin
      rdy_s1_q <= puf_resp_ready;
      rdy_s_q  <= rdy_s1_q;
      bit_s1_q <= puf_resp_bit;
      bit_s_q  <= bit_s1_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold value before the case so no path infers a latch.
    state_d   = state_q;
    puf_c_d   = puf_c_q;
    ones_d    = ones_q;
    eval_d    = eval_q;
    err_d     = err_q;
    setup_d   = setup_q;
    wait_d    = wait_q;
    relax_d   = relax_q;
    rsp_bit_d = rsp_bit_q;
    rsp_err_d = rsp_err_q;
    wait_nxt  = wait_q + WW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (ch_valid && ch_ready_q) begin
          puf_c_d = ch_data;
          ones_d  = '0;
          eval_d  = '0;
          err_d   = 1'b0;
          setup_d = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_q == SETUP_LAST) state_d = S_FIRE;
        else                       setup_d = setup_q + SW'(1);
      end
      S_FIRE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_s_q) begin
          state_d = S_SAMPLE;
        end else if (wait_nxt == TIMEOUT_L) begin
          // A missing arrival counts as a 0 vote and flags the response.
          err_d   = 1'b1;
          eval_d  = eval_q + CW'(1);
          relax_d = '0;
          state_d = S_RELAX;
        end else begin
          wait_d = wait_nxt;
        end
      end
      S_SAMPLE: begin
        ones_d  = ones_q + CW'(bit_s_q);
        eval_d  = eval_q + CW'(1);
        relax_d = '0;
        state_d = S_RELAX;
      end
      S_RELAX: begin
        if (relax_q != RELAX_LAST) begin
          relax_d = relax_q + RW'(1);
        end else if (!rdy_s_q) begin
          if (eval_q == NEVAL_L) begin
            rsp_bit_d = (ones_q > HALF_L);
            rsp_err_d = err_q;
            state_d   = S_DONE;
          end else begin
            state_d = S_FIRE;
          end
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      puf_c_q     <= '0;
      ones_q      <= '0;
      eval_q      <= '0;
      err_q       <= 1'b0;
      setup_q     <= '0;
      wait_q      <= '0;
      relax_q     <= '0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      ch_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      puf_tig_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      puf_c_q     <= puf_c_d;
      ones_q      <= ones_d;
      eval_q      <= eval_d;
      err_q       <= err_d;
      setup_q     <= setup_d;
      wait_q      <= wait_d;
      relax_q     <= relax_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_err_q   <= rsp_err_d;
      ch_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      puf_tig_q   <= (state_d == S_FIRE) || (state_d == S_WAIT);
      rsp_valid_q <= (state_d == S_DONE);
    end
  end

  assign ch_ready  = ch_ready_q;
  assign busy      = busy_q;
  assign puf_c     = puf_c_q;
  assign puf_tig   = puf_tig_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;
`ifdef APUF_SOFT_RESP_EN
  assign rsp_ones  = ones_q;
`endif

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl: behavioural PUF model, vote model and per-cycle checker.
module tb_apuf_eval_ctrl;

  localparam int NSTAGE      = 64;
  localparam int NEVAL       = 5;
  localparam int SETUP_CYC   = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int RELAX_CYC   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ch_valid = 1'b0;
  logic              ch_ready;
  logic [NSTAGE-1:0] ch_data = '0;
  logic [NSTAGE-1:0] puf_c;
  logic              puf_tig;
  logic              puf_resp_ready = 1'b0;
  logic              puf_resp_bit = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_bit;
  logic              rsp_err;
  logic              busy;
`ifdef APUF_SOFT_RESP_EN
  logic [$clog2(NEVAL+1)-1:0] rsp_ones;
`endif

  apuf_eval_ctrl #(
    .NSTAGE(NSTAGE), .NEVAL(NEVAL), .SETUP_CYC(SETUP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RELAX_CYC(RELAX_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .puf_c(puf_c), .puf_tig(puf_tig),
    .puf_resp_ready(puf_resp_ready), .puf_resp_bit(puf_resp_bit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bit(rsp_bit), .rsp_err(rsp_err), .busy(busy)
`ifdef APUF_SOFT_RESP_EN
    , .rsp_ones(rsp_ones)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // PUF behaviour and expected-response model for the current challenge
  logic [NEVAL-1:0]  pat = '0;
  int                rdy_delay = 3;
  bit                never_rdy = 1'b0;
  int                hold_after = 0;
  logic [NSTAGE-1:0] exp_ch = '0;
  logic              exp_bit = 1'b0;
  logic              exp_err = 1'b0;
  int                exp_ones = 0;
  int                fires = 0;
  int                hi_min = 1000000, hi_max = 0, lo_min = 1000000;

  task automatic setup_puf(input logic [NEVAL-1:0] p, input int dly, input bit never, input int hold);
    int ones = 0;
    pat = p; rdy_delay = dly; never_rdy = never; hold_after = hold;
    fires = 0; hi_min = 1000000; hi_max = 0; lo_min = 1000000;
    for (int i = 0; i < NEVAL; i++) if (!never && p[i]) ones++;
    exp_ones = ones;
    exp_bit  = (ones > NEVAL / 2);
    exp_err  = never;
  endtask

  // Arbiter PUF: answers rdy_delay cycles after the trigger, holds ready hold_after cycles past its fall.
  initial begin
    logic tig_prev = 1'b0;
    logic bit_now = 1'b0;
    int   cyc = 0, hi_len = 0, lo_len = 0, hold_left = 0;
    forever begin
      @(negedge clk);
      if (puf_tig && !tig_prev) begin
        check("fire_while_resp_ready", 64'(puf_resp_ready), 64'(0));
        if (fires > 0 && lo_len < lo_min) lo_min = lo_len;
        bit_now = pat[fires % NEVAL];
        fires++;
        cyc = 0;
        hi_len = 0;
      end
      if (!puf_tig && tig_prev) begin
        if (hi_len < hi_min) hi_min = hi_len;
        if (hi_len > hi_max) hi_max = hi_len;
        hold_left = hold_after;
        lo_len = 0;
      end
      if (puf_tig) begin
        cyc++;
        hi_len++;
        if (!never_rdy && cyc >= rdy_delay) begin
          puf_resp_ready = 1'b1;
          puf_resp_bit   = bit_now;
        end
      end else begin
        lo_len++;
        if (hold_left > 0) hold_left--;
        else puf_resp_ready = 1'b0;
      end
      tig_prev = puf_tig;
    end
  end

  // Per-cycle checker, sampled 1ns after the active edge
  initial begin
    @(negedge rst_n);
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        check("rst_puf_tig", 64'(puf_tig), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ch_ready", 64'(ch_ready), 64'(0));
      end else begin
        if (busy) begin
          check("busy_ch_ready_low", 64'(ch_ready), 64'(0));
          check("puf_c_constant", puf_c, exp_ch);
        end else begin
          check("idle_tig_low", 64'(puf_tig), 64'(0));
          check("idle_no_rsp", 64'(rsp_valid), 64'(0));
        end
        if (rsp_valid) begin
          check("model_rsp_bit", 64'(rsp_bit), 64'(exp_bit));
          check("model_rsp_err", 64'(rsp_err), 64'(exp_err));
          check("done_tig_low", 64'(puf_tig), 64'(0));
`ifdef APUF_SOFT_RESP_EN
          check("model_rsp_ones", 64'(rsp_ones), 64'(exp_ones));
`endif
        end
      end
    end
  end

  task automatic offer(input logic [NSTAGE-1:0] ch);
    int n = 0;
    exp_ch = ch; ch_data = ch; ch_valid = 1'b1;
    while (!ch_ready && n < 200) begin @(negedge clk); n++; end
    check("ch_accept", 64'(ch_ready), 64'(1));
    @(negedge clk);
    ch_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic collect(input int hold, input bit give_next, input logic [NSTAGE-1:0] nxt,
                         input logic lit_bit, input logic lit_err, input int lit_ones);
    int n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    check("rsp_valid_seen", 64'(rsp_valid), 64'(1));
    check("fire_count", 64'(fires), 64'(NEVAL));
    for (int i = 0; i < hold; i++) begin
      if (give_next) begin ch_data = nxt; ch_valid = 1'b1; end
      @(negedge clk);
      check("bp_ch_ready_low", 64'(ch_ready), 64'(0));
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'(1));
    end
    check("lit_rsp_bit", 64'(rsp_bit), 64'(lit_bit));
    check("lit_rsp_err", 64'(rsp_err), 64'(lit_err));
`ifdef APUF_SOFT_RESP_EN
    check("lit_rsp_ones", 64'(rsp_ones), 64'(lit_ones));
`else
    if (lit_ones < 0) check("lit_ones_arg", 64'(lit_ones), 64'(0));
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("reset_puf_c", puf_c, 64'(0));
    check("reset_rsp_bit", 64'(rsp_bit), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ch_ready", 64'(ch_ready), 64'(1));

    // rsp_ready with no pending response must do nothing
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    check("stray_rsp_ready_busy", 64'(busy), 64'(0));

    // All ones, ready 3 cycles after trigger
    setup_puf(5'b11111, 3, 1'b0, 0);
    offer(64'hDEAD_BEEF_0123_4567);
    collect(0, 1'b0, '0, 1'b1, 1'b0, 5);
    check("relax_min_gap", 64'(lo_min >= RELAX_CYC), 64'(1));

    // Votes 1,0,1,0,0
    setup_puf(5'b00101, 3, 1'b0, 0);
    offer(64'h0123_4567_89AB_CDEF);
    collect(0, 1'b0, '0, 1'b0, 1'b0, 2);

    // Never ready: every evaluation times out
    setup_puf(5'b11111, 3, 1'b1, 0);
    offer(64'hFFFF_0000_FFFF_0000);
    collect(0, 1'b0, '0, 1'b0, 1'b1, 0);
    check("timeout_tig_min", 64'(hi_min >= TIMEOUT_CYC), 64'(1));
    check("timeout_tig_max", 64'(hi_max <= TIMEOUT_CYC + 2), 64'(1));

    // Backpressure with a new challenge offered while the response is pending
    setup_puf(5'b10111, 3, 1'b0, 0);
    offer(64'hA5A5_A5A5_5A5A_5A5A);
    collect(20, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 4);
    setup_puf(5'b01011, 3, 1'b0, 0);
    offer(64'h1111_2222_3333_4444);
    collect(0, 1'b0, '0, 1'b1, 1'b0, 3);

    // Reset in the middle of WAIT
    setup_puf(5'b11111, 8, 1'b0, 0);
    offer(64'h0F0F_0F0F_F0F0_F0F0);
    n = 0;
    while (!puf_tig && n < 100) begin @(negedge clk); n++; end
    check("abort_reached_fire", 64'(puf_tig), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_tig_low", 64'(puf_tig), 64'(0));
    check("abort_rsp_valid_low", 64'(rsp_valid), 64'(0));
    check("abort_puf_c_cleared", puf_c, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ch_ready", 64'(ch_ready), 64'(1));
    setup_puf(5'b01000, 3, 1'b0, 0);
    offer(64'h7777_8888_9999_AAAA);
    collect(0, 1'b0, '0, 1'b0, 1'b0, 1);

    // resp_ready held 10 cycles past trigger fall: no refire until it drops
    setup_puf(5'b11010, 3, 1'b0, 10);
    offer(64'hCAFE_F00D_1234_5678);
    collect(0, 1'b0, '0, 1'b1, 1'b0, 3);
    check("relax_waits_for_ready_drop", 64'(lo_min >= 12), 64'(1));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Sequencer for one arbiter-PUF instance.
- Accepts a challenge over a valid/ready handshake, drives the challenge and trigger lines, and waits for both delay paths to arrive.
- Samples the arbiter output, repeats the evaluation NEVAL times and majority-votes the result.
- Sits between the challenge source (UART/host FIFO) and the PUF core; one controller per PUF.

Parameters:
- NSTAGE, 64, challenge width / number of switch stages
- NEVAL, 5, evaluations per challenge (odd, 1..255)
- SETUP_CYC, 4, cycles the challenge is held stable with trigger low before firing (>=1)
- TIMEOUT_CYC, 255, max cycles to wait for puf_resp_ready after firing
- RELAX_CYC, 4, cycles trigger stays low after a sample before the next fire (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_valid  in  1  challenge offered
- ch_ready  out  1  controller can accept a challenge
- ch_data  in  NSTAGE  challenge bits
- puf_c  out  NSTAGE  challenge to switch chain
- puf_tig  out  1  trigger to PUF
- puf_resp_ready  in  1  both paths arrived (async to clk)
- puf_resp_bit  in  1  arbiter latch output (async to clk)
- rsp_valid  out  1  voted response available
- rsp_ready  in  1  consumer accepts response
- rsp_bit  out  1  majority-voted response
- rsp_err  out  1  at least one evaluation timed out
- busy  out  1  controller not in IDLE

Behaviour:
- Reset values (async, rst_n=0): state IDLE, ch_ready=0 during reset then 1 in IDLE, puf_c=0, puf_tig=0, rsp_valid=0, rsp_bit=0, rsp_err=0, busy=0; all counters 0.
- puf_resp_ready and puf_resp_bit each pass through a 2-flop synchronizer; all decisions use the synchronized versions (rdy_s, bit_s).
- IDLE: ch_ready=1. On ch_valid&ch_ready: latch ch_data into puf_c, clear ones_cnt/eval_cnt/err flag, go to SETUP. ch_ready=0 in every other state.
- SETUP: puf_tig=0, count SETUP_CYC cycles, then go to FIRE.
- FIRE: puf_tig=1 (held), wait counter cleared; go to WAIT next cycle.
- WAIT: puf_tig=1.
  - rdy_s=1: go to SAMPLE.
  - Wait counter reaches TIMEOUT_CYC with rdy_s=0: set err flag, count the evaluation as a 0 vote, go to RELAX.
- SAMPLE: one cycle; ones_cnt += bit_s; eval_cnt += 1; go to RELAX.
- RELAX: puf_tig=0.
  - Leave only after RELAX_CYC cycles have elapsed AND rdy_s=0.
  - If rdy_s does not drop, stay (no timeout).
  - Exit: eval_cnt<NEVAL goes to FIRE; else go to DONE.
  - The timed-out evaluation also increments eval_cnt.
- DONE: rsp_valid=1, rsp_bit = (ones_cnt > NEVAL/2) (integer division; a tie is impossible for odd NEVAL, resolves to 0 otherwise), rsp_err = err flag. Outputs are stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&rsp_ready go to IDLE (ch_ready=1 next cycle).
- Widths: ones_cnt and eval_cnt are clog2(NEVAL+1) bits; wait counter is clog2(TIMEOUT_CYC+1) bits; setup/relax counters are sized to their parameters. No wrap: counters compare with == to their limits.
- puf_c changes only on IDLE accept; it is constant for all NEVAL evaluations.
- Reset asserted mid-operation: immediate return to IDLE, puf_tig=0, any pending response is discarded.
- ch_valid during busy is ignored (ch_ready=0); rsp_ready without rsp_valid has no effect.
- Throughput/latency per challenge (no timeout, rdy_s immediate): 1 + SETUP_CYC + NEVAL*(FIRE+WAIT+sync+SAMPLE+RELAX) cycles; the bench checks ordering, not an exact count.

Optional Feature:
- Macro APUF_SOFT_RESP_EN.
- When defined: extra output rsp_ones [clog2(NEVAL+1)-1:0] equals ones_cnt, valid with rsp_valid and held under backpressure; 0 at reset. Provides a reliability/soft-response measure.
- When undefined: port absent; behaviour otherwise identical.

Test Plan:
- NEVAL=5, PUF model returns bit=1 every eval with resp_ready 3 cycles after tig -> rsp_valid, rsp_bit=1, rsp_err=0, exactly 5 tig rising edges, puf_c = offered challenge throughout.
- Model returns 1,0,1,0,0 -> rsp_bit=0; with APUF_SOFT_RESP_EN, rsp_ones=2.
- Model never raises resp_ready, TIMEOUT_CYC=16 -> each eval times out after 16 WAIT cycles; rsp_bit=0, rsp_err=1, 5 fires.
- Hold rsp_ready=0 for 20 cycles in DONE, offer new ch_valid -> rsp_bit/rsp_err stable, ch_ready=0, new challenge accepted only after the rsp handshake.
- Assert rst_n=0 during WAIT -> puf_tig=0 and rsp_valid=0 immediately; after release, ch_ready=1 and a fresh challenge completes normally.
- resp_ready held high 10 cycles after tig drops -> controller stays in RELAX, no new fire until ready deasserts.
